rv32_exec_alu: RTL and testbench
================================

Name: rv32_exec_alu

Overview:
- Integer execute unit of the single-cycle RV32I core.
- Sits between the instruction decoder and the register file.
- Takes the register operands, the immediate and the decoded instruction class/function fields, and produces one 32-bit result: writeback data, memory address or branch-taken flag.
- The result is registered, giving one cycle of latency.

Parameters:
RESET_VAL, 32'h0000_0000, value loaded into w_res on reset

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST_X  input  1  reset, synchronous, active-high (the RST_X name is kept from the codebase; polarity is high)
pc  input  32  PC of the instruction being executed
rrs1  input  32  rs1 register value
rrs2  input  32  rs2 register value
imm  input  32  sign-extended immediate from the decoder
instr_type  input  5  instruction class code, see Behaviour
funct3  input  3  instr[14:12]
funct7  input  7  instr[31:25] (for OP-IMM shifts equals imm[11:5])
w_res  output  32  registered result

Behaviour:
- Every rising CLK edge: if RST_X=1 then w_res<=RESET_VAL, else w_res<=f(inputs sampled at that edge). One-cycle latency, no stall or handshake, a new operation every cycle.
- Reset mid-stream discards the in-flight result. The first post-reset result appears on the edge after RST_X falls.
- instr_type codes:
  - 0 OP: register-register, operand B=rrs2.
  - 1 OP_IMM: operand B=imm.
  - 2 LUI: imm.
  - 3 AUIPC: pc+imm.
  - 4 JAL: pc+4.
  - 5 JALR: pc+4.
  - 6 BRANCH: flag.
  - 7 LOAD: rrs1+imm.
  - 8 STORE: rrs1+imm.
  - 9..31: result 0.
- OP / OP_IMM by funct3, with A=rrs1:
  - 000: add. In OP only, funct7[5]=1 selects A-B. OP_IMM always adds.
  - 001: SLL, shift amount B[4:0].
  - 010: SLT, signed compare, result 1/0.
  - 011: SLTU, unsigned compare, result 1/0.
  - 100: XOR.
  - 101: funct7[5]=0 gives SRL, 1 gives SRA (sign-filling). Shift amount B[4:0].
  - 110: OR.
  - 111: AND.
- OP with funct7=0000001 is the M-extension; see Optional Feature.
- All arithmetic is modulo 2^32: overflow wraps, no flags. pc+4 wraps at 32'hFFFF_FFFC -> 0.
- BRANCH: w_res=32'h1 if taken, else 0, by funct3:
  - 000: BEQ. 001: BNE.
  - 100: BLT, signed. 101: BGE, signed.
  - 110: BLTU. 111: BGEU.
  - 010 and 011: result 0.
- Shift by 0 returns A unchanged. SRA of 32'h8000_0000 by 31 gives 32'hFFFF_FFFF.
- funct7 bits other than [5] (and [0] under the optional feature) are ignored. No illegal-instruction detection.

Optional Feature:
- Macro: RV32M_MUL_EN.
- Defined: OP with funct7=0000001 performs the RV32M multiply, by funct3:
  - 000: MUL, low 32 bits.
  - 001: MULH, signed x signed, high 32 bits.
  - 010: MULHSU, signed rrs1 x unsigned rrs2, high 32 bits.
  - 011: MULHU, unsigned, high 32 bits.
  - 100-111 (divide/remainder): result 0.
  - Latency stays one cycle.
- Not defined: any OP with funct7=0000001 yields w_res=0. No multiplier logic is synthesized.

Test Plan:
- Reset: hold RST_X=1 with OP ADD rrs1=5 rrs2=7 -> w_res=0. Release -> next edge w_res=12. Assert RST_X for one cycle mid-stream -> w_res=0 that cycle.
- OP: rrs1=5, rrs2=7, funct7=0100000, funct3=000 -> 32'hFFFF_FFFE. rrs1=32'h8000_0000, rrs2=31, funct3=101, funct7[5]=1 -> 32'hFFFF_FFFF. Same with funct7=0 -> 1.
- OP_IMM and compares:
  - ADDI with rrs1=32'hFFFF_FFFF, imm=1 -> 0.
  - SLTI with rrs1=-1, imm=0 -> 1.
  - SLTIU with rrs1=-1, imm=0 -> 0.
  - ANDI with rrs1=32'hF0F0, imm=32'hFF -> 32'hF0.
- Upper/jump/mem: pc=32'h100.
  - LUI imm=32'h1234_5000 -> 32'h1234_5000.
  - AUIPC with the same imm -> 32'h1234_5100.
  - JAL -> 32'h104.
  - LOAD with rrs1=32'h2000, imm=-4 -> 32'h1FFC.
- Branch:
  - BLT -1 vs 1 -> 1.
  - BLTU -1 vs 1 -> 0.
  - BEQ 3 vs 3 -> 1.
  - BNE 3 vs 3 -> 0.
  - funct3=010 -> 0.
  - instr_type=20 -> 0.
- RV32M_MUL_EN:
  - MUL 32'hFFFF_FFFF x 2 -> 32'hFFFF_FFFE.
  - MULH -1 x -1 -> 0.
  - MULHU -1 x -1 -> 32'hFFFF_FFFE.
  - Macro undefined: all three -> 0.

Source files
------------

// File: rtl/rv32_exec_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_exec_alu_if
// Description : Operand/result bundle between the RV32I decoder and the
//               execute ALU.
//   pc         - PC of the instruction being executed
//   rrs1/rrs2  - register operands
//   imm        - sign-extended immediate
//   instr_type - instruction class code
//   funct3     - instr[14:12]
//   funct7     - instr[31:25]
//   w_res      - registered ALU result
//   master     : decoder side (drives operands, receives w_res)
//   slave      : ALU side (receives operands, drives w_res)
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_exec_alu_if;
    logic [31:0] pc;
    logic [31:0] rrs1;
    logic [31:0] rrs2;
    logic [31:0] imm;
    logic [4:0]  instr_type;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] w_res;

    modport master (
        output pc, rrs1, rrs2, imm, instr_type, funct3, funct7,
        input  w_res
    );

    modport slave (
        input  pc, rrs1, rrs2, imm, instr_type, funct3, funct7,
        output w_res
    );
endinterface
`default_nettype wire

// File: rtl/rv32_exec_alu.sv
`default_nettype none
// ============================================================================
// Module      : rv32_exec_alu
// Description : Integer execute unit of the single-cycle RV32I core. Produces
//               one registered 32-bit result per cycle (writeback data,
//               memory address or branch-taken flag), one cycle of latency.
//   CLK   - system clock, rising edge
//   RST_X - synchronous reset, active HIGH; loads RESET_VAL into w_res
//   bus   - rv32_exec_alu_if.slave (operands in, w_res out)
// Optional : define RV32M_MUL_EN to enable the RV32M multiply group
//            (MUL/MULH/MULHSU/MULHU); otherwise OP with funct7=0000001
//            returns 0 and no multiplier is built.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_exec_alu #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RST_X,
    rv32_exec_alu_if.slave  bus
);

    localparam logic [4:0] c_OP     = 5'd0;
    localparam logic [4:0] c_OP_IMM = 5'd1;
    localparam logic [4:0] c_LUI    = 5'd2;
    localparam logic [4:0] c_AUIPC  = 5'd3;
    localparam logic [4:0] c_JAL    = 5'd4;
    localparam logic [4:0] c_JALR   = 5'd5;
    localparam logic [4:0] c_BRANCH = 5'd6;
    localparam logic [4:0] c_LOAD   = 5'd7;
    localparam logic [4:0] c_STORE  = 5'd8;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_shamt;
    logic        w_is_op;
    logic        w_is_m;
    logic        w_lt;
    logic        w_ltu;
    logic        w_eq;
    logic [31:0] w_alu;
    logic        w_taken;
    logic [31:0] w_mul;
    logic [31:0] w_next;
    logic [31:0] r_res;
    logic        w_unused_funct7;

    assign w_is_op = (bus.instr_type == c_OP);
    // Branches compare rs1 against rs2, as OP does; only OP_IMM uses imm.
    assign w_a     = bus.rrs1;
    assign w_b     = (w_is_op || bus.instr_type == c_BRANCH) ? bus.rrs2 : bus.imm;
    assign w_shamt = w_b[4:0];
    assign w_is_m  = w_is_op && bus.funct7[0];

    assign w_lt  = $signed(w_a) < $signed(w_b);
    assign w_ltu = w_a < w_b;
    assign w_eq  = w_a == w_b;

    // Only funct7[5] (sub/arith-shift) and funct7[0] (M group) are decoded.
    assign w_unused_funct7 = ^{bus.funct7[6], bus.funct7[4:1]};

    always_comb begin
        w_alu = '0;
        case (bus.funct3)
            3'b000:  w_alu = (w_is_op && bus.funct7[5]) ? (w_a - w_b) : (w_a + w_b);
            3'b001:  w_alu = w_a << w_shamt;
            3'b010:  w_alu = {31'd0, w_lt};
            3'b011:  w_alu = {31'd0, w_ltu};
            3'b100:  w_alu = w_a ^ w_b;
            3'b101:  w_alu = bus.funct7[5] ? $unsigned($signed(w_a) >>> w_shamt)
                                           : (w_a >> w_shamt);
            3'b110:  w_alu = w_a | w_b;
            default: w_alu = w_a & w_b;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (bus.funct3)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = ~w_eq;
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = ~w_lt;
            3'b110:  w_taken = w_ltu;
            3'b111:  w_taken = ~w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

`ifdef RV32M_MUL_EN
    // One shared 33x33 signed multiplier: each operand gets a sign bit only
    // when the selected variant treats it as signed, then both are extended
    // to 64 bits so a plain 64-bit product yields the exact result.
    logic        w_a_sgn;
    logic        w_b_sgn;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_mul_p;

    assign w_a_sgn = (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
    assign w_b_sgn = (bus.funct3[1:0] == 2'b01);
    assign w_mul_a = {{32{w_a_sgn & w_a[31]}}, w_a};
    assign w_mul_b = {{32{w_b_sgn & w_b[31]}}, w_b};
    assign w_mul_p = w_mul_a * w_mul_b;

    always_comb begin
        w_mul = '0;
        if (!bus.funct3[2]) begin
            w_mul = (bus.funct3[1:0] == 2'b00) ? w_mul_p[31:0] : w_mul_p[63:32];
        end
    end
`else
    assign w_mul = '0;
`endif

    always_comb begin
        w_next = '0;
        case (bus.instr_type)
            c_OP, c_OP_IMM: w_next = w_is_m ? w_mul : w_alu;
            c_LUI:          w_next = bus.imm;
            c_AUIPC:        w_next = bus.pc + bus.imm;
            c_JAL, c_JALR:  w_next = bus.pc + 32'd4;
            c_BRANCH:       w_next = {31'd0, w_taken};
            c_LOAD, c_STORE: w_next = bus.rrs1 + bus.imm;
            default:        w_next = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST_X) begin
            r_res <= RESET_VAL;
        end else begin
            r_res <= w_next;
        end
    end

    assign bus.w_res = r_res;

endmodule
`default_nettype wire

// File: tb/tb_rv32_exec_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_exec_alu
// Description : Self-checking bench for rv32_exec_alu: directed cases plus
//               randomized operations against a behavioural reference model.
//               Define RV32M_MUL_EN for both bench and RTL to cover RV32M.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_exec_alu;

    localparam logic [31:0] c_RESET_VAL = 32'h0000_0000;

    logic clk;
    logic rst;

    rv32_exec_alu_if bus ();

    rv32_exec_alu #(
        .RESET_VAL (c_RESET_VAL)
    ) u_dut (
        .CLK   (clk),
        .RST_X (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_fail;
    logic        r_pend_valid;
    logic [31:0] r_pend_exp;
    string       r_pend_tag;

    task automatic check_result(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: computed from the ISA rules with 64-bit integer maths.
    function automatic logic [31:0] ref_alu(input logic [4:0] t, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] pcv,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] immv);
        longint          sa, sb, sbb, pw, q;
        longint unsigned ua, ub, ubb;
        logic [31:0]     opb;
        logic [63:0]     p;
        int              sh;
        logic [31:0]     r;
        r   = 32'd0;
        opb = (t == 5'd0) ? b : immv;
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ubb = {32'd0, opb};
        sa  = a[31]   ? longint'(ua)  - 64'sd4294967296 : longint'(ua);
        sb  = b[31]   ? longint'(ub)  - 64'sd4294967296 : longint'(ub);
        sbb = opb[31] ? longint'(ubb) - 64'sd4294967296 : longint'(ubb);
        sh  = int'(ubb % 32);
        pw  = 64'sd1 << sh;
        case (t)
            5'd0, 5'd1: begin
                if (t == 5'd0 && f7 == 7'b0000001) begin
`ifdef RV32M_MUL_EN
                    case (f3)
                        3'd0: begin p = ua * ub; r = p[31:0]; end
                        3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
                        3'd2: begin p = 64'(sa * longint'(ub)); r = p[63:32]; end
                        3'd3: begin p = ua * ub; r = p[63:32]; end
                        default: r = 32'd0;
                    endcase
`else
                    r = 32'd0;
`endif
                end else begin
                    case (f3)
                        3'd0: r = (t == 5'd0 && f7[5]) ? 32'(ua - ubb) : 32'(ua + ubb);
                        3'd1: r = 32'(ua * longint'(pw));
                        3'd2: r = (sa < sbb) ? 32'd1 : 32'd0;
                        3'd3: r = (ua < ubb) ? 32'd1 : 32'd0;
                        3'd4: r = a ^ opb;
                        3'd5: begin
                            if (f7[5]) begin
                                q = sa / pw;
                                if (sa < 0 && (sa % pw) != 0) q = q - 1;
                                r = 32'(q);
                            end else begin
                                r = 32'(ua / longint'(pw));
                            end
                        end
                        3'd6: r = a | opb;
                        default: r = a & opb;
                    endcase
                end
            end
            5'd2: r = immv;
            5'd3: r = 32'(longint'({32'd0, pcv}) + longint'({32'd0, immv}));
            5'd4, 5'd5: r = 32'(longint'({32'd0, pcv}) + 4);
            5'd6: begin
                case (f3)
                    3'd0: r = (a == b) ? 32'd1 : 32'd0;
                    3'd1: r = (a != b) ? 32'd1 : 32'd0;
                    3'd4: r = (sa <  sb) ? 32'd1 : 32'd0;
                    3'd5: r = (sa >= sb) ? 32'd1 : 32'd0;
                    3'd6: r = (ua <  ub) ? 32'd1 : 32'd0;
                    3'd7: r = (ua >= ub) ? 32'd1 : 32'd0;
                    default: r = 32'd0;
                endcase
            end
            5'd7, 5'd8: r = 32'(ua + {32'd0, immv});
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // One operation per cycle: at each falling edge check the result of the
    // previous operation, then present the next one.
    task automatic step(input string tag, input logic r, input logic [4:0] t,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] pcv, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] immv,
                        input logic [31:0] exp);
        @(negedge clk);
        if (r_pend_valid) check_result(r_pend_tag, bus.w_res, r_pend_exp);
        rst            = r;
        bus.instr_type = t;
        bus.funct3     = f3;
        bus.funct7     = f7;
        bus.pc         = pcv;
        bus.rrs1       = a;
        bus.rrs2       = b;
        bus.imm        = immv;
        r_pend_valid   = 1'b1;
        r_pend_exp     = exp;
        r_pend_tag     = tag;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    logic [31:0] m_mul, m_mulh, m_mulhu;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        r_pend_valid = 1'b0;
        r_pend_exp   = '0;
        r_pend_tag   = "";
        rst          = 1'b1;
        bus.pc = '0; bus.rrs1 = '0; bus.rrs2 = '0; bus.imm = '0;
        bus.instr_type = '0; bus.funct3 = '0; bus.funct7 = '0;

        // Reset behaviour
        step("rst_hold0",   1, 5'd0, 3'd0, 7'h00, 32'h0, 32'd5, 32'd7, 32'h0, c_RESET_VAL);
        step("rst_hold1",   1, 5'd0, 3'd0, 7'h00, 32'h0, 32'd5, 32'd7, 32'h0, c_RESET_VAL);
        step("rst_release", 0, 5'd0, 3'd0, 7'h00, 32'h0, 32'd5, 32'd7, 32'h0, 32'd12);
        step("add_1_2",     0, 5'd0, 3'd0, 7'h00, 32'h0, 32'd1, 32'd2, 32'h0, 32'd3);
        step("rst_mid",     1, 5'd0, 3'd0, 7'h00, 32'h0, 32'd9, 32'd9, 32'h0, c_RESET_VAL);
        step("post_rst",    0, 5'd0, 3'd0, 7'h00, 32'h0, 32'd10, 32'd20, 32'h0, 32'd30);

        // OP
        step("sub_5_7", 0, 5'd0, 3'd0, 7'h20, 32'h0, 32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE);
        step("sra_31",  0, 5'd0, 3'd5, 7'h20, 32'h0, 32'h8000_0000, 32'd31, 32'h0, 32'hFFFF_FFFF);
        step("srl_31",  0, 5'd0, 3'd5, 7'h00, 32'h0, 32'h8000_0000, 32'd31, 32'h0, 32'h1);
        step("sll_0",   0, 5'd0, 3'd1, 7'h00, 32'h0, 32'h1234_5678, 32'd0, 32'h0, 32'h1234_5678);

        // OP_IMM
        step("addi_wrap", 0, 5'd1, 3'd0, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0);
        step("slti",      0, 5'd1, 3'd2, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1);
        step("sltiu",     0, 5'd1, 3'd3, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        step("andi",      0, 5'd1, 3'd7, 7'h00, 32'h0, 32'h0000_F0F0, 32'h0, 32'hFF, 32'hF0);

        // Upper / jump / memory
        step("lui",      0, 5'd2, 3'd0, 7'h00, 32'h100, 32'h0, 32'h0, 32'h1234_5000, 32'h1234_5000);
        step("auipc",    0, 5'd3, 3'd0, 7'h00, 32'h100, 32'h0, 32'h0, 32'h1234_5000, 32'h1234_5100);
        step("jal",      0, 5'd4, 3'd0, 7'h00, 32'h100, 32'h0, 32'h0, 32'h0, 32'h104);
        step("jalr_wrap",0, 5'd5, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0);
        step("load",     0, 5'd7, 3'd2, 7'h00, 32'h100, 32'h2000, 32'h0, 32'hFFFF_FFFC, 32'h1FFC);
        step("store",    0, 5'd8, 3'd2, 7'h00, 32'h100, 32'h2000, 32'h0, 32'h10, 32'h2010);

        // Branch
        step("blt",      0, 5'd6, 3'd4, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h1);
        step("bltu",     0, 5'd6, 3'd6, 7'h00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        step("beq",      0, 5'd6, 3'd0, 7'h00, 32'h0, 32'd3, 32'd3, 32'h0, 32'h1);
        step("bne",      0, 5'd6, 3'd1, 7'h00, 32'h0, 32'd3, 32'd3, 32'h0, 32'h0);
        step("br_f3_2",  0, 5'd6, 3'd2, 7'h00, 32'h0, 32'd3, 32'd3, 32'h0, 32'h0);
        step("type_20",  0, 5'd20, 3'd0, 7'h00, 32'h100, 32'd3, 32'd3, 32'h55, 32'h0);

        // RV32M group
`ifdef RV32M_MUL_EN
        m_mul = 32'hFFFF_FFFE; m_mulh = 32'h0; m_mulhu = 32'hFFFF_FFFE;
`else
        m_mul = 32'h0; m_mulh = 32'h0; m_mulhu = 32'h0;
`endif
        step("mul",   0, 5'd0, 3'd0, 7'h01, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'h0, m_mul);
        step("mulh",  0, 5'd0, 3'd1, 7'h01, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, m_mulh);
        step("mulhu", 0, 5'd0, 3'd3, 7'h01, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, m_mulhu);
        step("div0",  0, 5'd0, 3'd4, 7'h01, 32'h0, 32'd100, 32'd7, 32'h0, 32'h0);

        // Randomized operations
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [4:0]  t;
            logic [2:0]  f3;
            logic [6:0]  f7;
            logic [31:0] pcv, a, b, immv;
            r    = ($urandom_range(0, 24) == 0);
            t    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(9, 31))
                                                : 5'($urandom_range(0, 8));
            f3   = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'h01;
            endcase
            pcv  = pick_val();
            a    = pick_val();
            b    = pick_val();
            immv = pick_val();
            step("random", r, t, f3, f7, pcv, a, b, immv,
                 r ? c_RESET_VAL : ref_alu(t, f3, f7, pcv, a, b, immv));
        end

        @(negedge clk);
        if (r_pend_valid) check_result(r_pend_tag, bus.w_res, r_pend_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
